// File: rtl/pc_pkg.sv
// Shared types for the program-counter / branch sequencer.
package pc_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2,
    BR_ALW  = 2'd3
  } br_cond_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  function automatic logic br_taken(input br_cond_t cond, input logic zero);
    case (cond)
      BR_EQ:   br_taken = zero;
      BR_NE:   br_taken = !zero;
      BR_ALW:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_target_file.sv
// Branch-target register file: one write port, one combinational read port,
// and detection of indices beyond NUM_TGT.
module pc_target_file #(
  parameter int unsigned L       = 10,
  parameter int unsigned NUM_TGT = 4,
  parameter int unsigned SEL_W   = $clog2(NUM_TGT)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_we,
  input  logic [L-1:0]     i_wdata,
  output logic [L-1:0]     o_rdata,
  output logic             o_invalid
);

  logic [L-1:0] r_tgt [NUM_TGT];
  logic         w_invalid;

  // Only reachable when NUM_TGT is not a power of two.
  assign w_invalid = (32'(i_sel) >= NUM_TGT);
  assign o_invalid = w_invalid;
  assign o_rdata   = w_invalid ? '0 : r_tgt[i_sel];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_TGT; i++) r_tgt[i] <= '0;
    end else if (i_we && !w_invalid) begin
      r_tgt[i_sel] <= i_wdata;
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter / fetch sequencer with Start/Halt run control and conditional branches.
// Optional return stack enabled by defining PC_CALL_STACK_EN.
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int unsigned L       = 10,
  parameter int unsigned NUM_TGT = 4,
  parameter int unsigned OFS_W   = 8,
  parameter int unsigned STK_D   = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [L-1:0]               StartAddr,
  input  logic                       Halt,
  input  logic [1:0]                 BrCond,
  input  logic                       Zero,
  input  logic [$clog2(NUM_TGT)-1:0] TgtSel,
  input  logic                       TgtWe,
  input  logic                       TgtRel,
  input  logic [L-1:0]               TgtData,
  input  logic [OFS_W-1:0]           Offset,
  input  logic                       Call,
  input  logic                       Ret,
  output logic [L-1:0]               ProgCtr,
  output logic                       Running,
  output logic                       Done,
  output logic                       SelErr,
  output logic                       StkErr
);

  localparam int unsigned SEL_W = $clog2(NUM_TGT);

  pc_state_t    r_state, w_state_d;
  logic [L-1:0] r_pc, w_pc_d, w_pc_inc, w_rel, w_wdata, w_tgt;
  logic         r_running, r_done, r_sel_err;
  logic         w_invalid, w_sel_use;

  assign w_pc_inc = r_pc + L'(1);
  assign w_rel    = r_pc + L'($signed(Offset));
  assign w_wdata  = TgtRel ? w_rel : TgtData;

  pc_target_file #(
    .L       (L),
    .NUM_TGT (NUM_TGT),
    .SEL_W   (SEL_W)
  ) u_tgt (
    .i_clk     (Clk),
    .i_rst     (Reset),
    .i_sel     (TgtSel),
    .i_we      (TgtWe),
    .i_wdata   (w_wdata),
    .o_rdata   (w_tgt),
    .o_invalid (w_invalid)
  );

`ifdef PC_CALL_STACK_EN
  localparam int unsigned SP_W  = $clog2(STK_D + 1);
  localparam int unsigned STK_W = $clog2(STK_D);

  logic [L-1:0]    r_stk [STK_D];
  logic [SP_W-1:0] r_sp;
  logic            r_stk_err, w_push, w_pop, w_stk_err_set;
  logic            w_empty, w_full;

  assign w_empty = (r_sp == '0);
  assign w_full  = (r_sp == SP_W'(STK_D));
  assign StkErr  = r_stk_err;
`else
  localparam int unsigned W_UNUSED_STK_D = STK_D;
  logic w_unused_ret;
  assign w_unused_ret = Ret;
  assign StkErr       = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_sel_use = 1'b0;
`ifdef PC_CALL_STACK_EN
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_stk_err_set = 1'b0;
`endif
    case (r_state)
      RUN: begin
        if (Halt) begin
          w_state_d = HALTED;
`ifdef PC_CALL_STACK_EN
        end else if (Ret) begin
          if (w_empty) begin
            w_pc_d        = w_pc_inc;
            w_stk_err_set = 1'b1;
          end else begin
            w_pop  = 1'b1;
            w_pc_d = r_stk[STK_W'(r_sp - SP_W'(1))];
          end
        end else if (Call) begin
          w_sel_use = 1'b1;
          if (w_invalid) begin
            w_pc_d = w_pc_inc;
          end else if (w_full) begin
            w_pc_d        = w_pc_inc;
            w_stk_err_set = 1'b1;
          end else begin
            w_push = 1'b1;
            w_pc_d = w_tgt;
          end
`else
        end else if (Call) begin
          w_sel_use = 1'b1;
          w_pc_d    = w_invalid ? w_pc_inc : w_tgt;
`endif
        end else if (br_taken(br_cond_t'(BrCond), Zero)) begin
          w_sel_use = 1'b1;
          w_pc_d    = w_invalid ? w_pc_inc : w_tgt;
        end else begin
          w_pc_d = w_pc_inc;
        end
      end
      IDLE, HALTED: begin
        if (Start) begin
          w_state_d = RUN;
          w_pc_d    = StartAddr;
        end
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_pc      <= w_pc_d;
      r_running <= (w_state_d == RUN);
      r_done    <= (w_state_d == HALTED);
      if ((TgtWe || w_sel_use) && w_invalid) r_sel_err <= 1'b1;
    end
  end

`ifdef PC_CALL_STACK_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < STK_D; i++) r_stk[i] <= '0;
      r_sp      <= '0;
      r_stk_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_stk[STK_W'(r_sp)] <= w_pc_inc;
        r_sp                <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_stk_err_set) r_stk_err <= 1'b1;
    end
  end
`endif

  assign ProgCtr = r_pc;
  assign Running = r_running;
  assign Done    = r_done;
  assign SelErr  = r_sel_err;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed table-driven bench for pc_branch_unit; the stack sequence runs when
// PC_CALL_STACK_EN is defined.
module tb_pc_branch_unit;

  logic       Clk = 1'b0;
  logic       Reset, Start, Halt, Zero, TgtWe, TgtRel, Call, Ret;
  logic [9:0] StartAddr, TgtData;
  logic [1:0] BrCond, TgtSel;
  logic [7:0] Offset;
  logic [9:0] ProgCtr, pc3;
  logic       Running, Done, SelErr, StkErr, run3, done3, selerr3, stkerr3;

  int n_total = 0;
  int n_bad   = 0;

  always #5 Clk = ~Clk;

  pc_branch_unit #(.L(10), .NUM_TGT(4), .OFS_W(8), .STK_D(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
    .BrCond(BrCond), .Zero(Zero), .TgtSel(TgtSel), .TgtWe(TgtWe), .TgtRel(TgtRel),
    .TgtData(TgtData), .Offset(Offset), .Call(Call), .Ret(Ret), .ProgCtr(ProgCtr),
    .Running(Running), .Done(Done), .SelErr(SelErr), .StkErr(StkErr)
  );

  // Three targets: TgtSel=3 is an invalid index for this instance only.
  pc_branch_unit #(.L(10), .NUM_TGT(3), .OFS_W(8), .STK_D(4)) dut3 (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr), .Halt(Halt),
    .BrCond(BrCond), .Zero(Zero), .TgtSel(TgtSel), .TgtWe(TgtWe), .TgtRel(TgtRel),
    .TgtData(TgtData), .Offset(Offset), .Call(Call), .Ret(Ret), .ProgCtr(pc3),
    .Running(run3), .Done(done3), .SelErr(selerr3), .StkErr(stkerr3)
  );

  typedef struct {
    logic st; logic [9:0] sa; logic hl; logic [1:0] bc; logic z; logic [1:0] sel;
    logic we; logic rel; logic [9:0] dat; logic [7:0] ofs; logic cl; logic rt;
    logic [9:0] pc; logic run; logic done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic st, logic [9:0] sa, logic hl, logic [1:0] bc, logic z,
                             logic [1:0] sel, logic we, logic rel, logic [9:0] dat,
                             logic [7:0] ofs, logic cl, logic rt, logic [9:0] pc,
                             logic run, logic done);
    vec_t t;
    t.st = st; t.sa = sa; t.hl = hl; t.bc = bc; t.z = z; t.sel = sel; t.we = we;
    t.rel = rel; t.dat = dat; t.ofs = ofs; t.cl = cl; t.rt = rt;
    t.pc = pc; t.run = run; t.done = done;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    Start = t.st; StartAddr = t.sa; Halt = t.hl; BrCond = t.bc; Zero = t.z;
    TgtSel = t.sel; TgtWe = t.we; TgtRel = t.rel; TgtData = t.dat; Offset = t.ofs;
    Call = t.cl; Ret = t.rt;
  endtask

  task automatic go(input vec_t t);
    apply(t);
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  initial begin
    // Filled in order; each row's expectation follows from the rows before it.
    tbl.push_back(v(1, 'h010, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h010, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h011, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h012, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 1, 1, 0, 'h200,  0,    0, 0, 'h013, 1, 0));
    tbl.push_back(v(1, 'h3C0, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h014, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 2, 1, 0, 'h020,  0,    0, 0, 'h015, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 2, 0, 0, 0,      0,    0, 0, 'h020, 1, 0));
    tbl.push_back(v(0, 0,     0, 1, 1, 1, 0, 0, 0,      0,    0, 0, 'h200, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 2, 0, 0, 0,      0,    0, 0, 'h020, 1, 0));
    tbl.push_back(v(0, 0,     0, 1, 0, 1, 0, 0, 0,      0,    0, 0, 'h021, 1, 0));
    tbl.push_back(v(0, 0,     0, 2, 0, 1, 0, 0, 0,      0,    0, 0, 'h200, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 2, 0, 0, 0,      0,    0, 0, 'h020, 1, 0));
    tbl.push_back(v(0, 0,     0, 2, 1, 1, 0, 0, 0,      0,    0, 0, 'h021, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 1, 1, 0, 0, 0,      0,    0, 0, 'h022, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 3, 1, 0, 'h100,  0,    0, 0, 'h023, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 3, 0, 0, 0,      0,    0, 0, 'h100, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 1, 1, 0,      'hF0, 0, 0, 'h101, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 0, 0, 0, 0,      0,    0, 0, 'h0F0, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 3, 1, 0, 'h3FF,  0,    0, 0, 'h0F1, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 3, 0, 0, 0,      0,    0, 0, 'h3FF, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h000, 1, 0));
    tbl.push_back(v(0, 0,     1, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h000, 0, 1));
    tbl.push_back(v(0, 0,     0, 3, 0, 3, 0, 0, 0,      0,    0, 0, 'h000, 0, 1));
    tbl.push_back(v(0, 0,     0, 1, 1, 3, 0, 0, 0,      0,    0, 0, 'h000, 0, 1));
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 1, 0, 'h123,  0,    0, 0, 'h000, 0, 1));
    tbl.push_back(v(0, 0,     0, 0, 0, 3, 0, 0, 0,      0,    1, 0, 'h000, 0, 1));
    tbl.push_back(v(0, 0,     1, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h000, 0, 1));
    tbl.push_back(v(1, 'h030, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h030, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 2, 1, 0, 'h040,  0,    0, 0, 'h031, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 2, 1, 0, 'h050,  0,    0, 0, 'h040, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 2, 0, 0, 0,      0,    0, 0, 'h050, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 1, 1, 1, 0,      'h05, 0, 0, 'h051, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 1, 0, 0, 0,      0,    0, 0, 'h055, 1, 0));
    tbl.push_back(v(0, 0,     1, 3, 0, 1, 0, 0, 0,      0,    0, 0, 'h055, 0, 1));
    tbl.push_back(v(1, 'h3F0, 0, 0, 0, 0, 0, 0, 0,      0,    0, 0, 'h3F0, 1, 0));
    tbl.push_back(v(0, 0,     0, 3, 0, 0, 0, 0, 0,      0,    0, 0, 'h123, 1, 0));
    tbl.push_back(v(0, 0,     0, 0, 0, 1, 0, 0, 0,      0,    1, 0, 'h055, 1, 0));
`ifdef PC_CALL_STACK_EN
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 0, 0, 0,      0,    0, 1, 'h124, 1, 0));
`else
    tbl.push_back(v(0, 0,     0, 0, 0, 0, 0, 0, 0,      0,    0, 1, 'h056, 1, 0));
`endif

    // Reset state.
    Reset = 1'b1;
    apply(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge Clk);
    #1;
    chk("reset pc", 32'(ProgCtr), 0);
    chk("reset flags", {Running, Done, SelErr, StkErr}, 0);
    Reset = 1'b0;

    // Asynchronous reset taken mid-cycle while running at 0x05A.
    go(v(1, 'h050, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 10; i++) go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pre-reset pc", 32'(ProgCtr), 'h05A);
    chk("pre-reset running", 32'(Running), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async reset pc", 32'(ProgCtr), 0);
    chk("async reset running", 32'(Running), 0);
    @(negedge Clk);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      go(tbl[i]);
      chk($sformatf("row%0d pc", i), 32'(ProgCtr), 32'(tbl[i].pc));
      chk($sformatf("row%0d flags", i), {Running, Done, SelErr, StkErr},
          {tbl[i].run, tbl[i].done, 2'b00});
    end

    // Invalid target index on the three-target instance.
    do_reset();
    chk("sel3 reset selerr", 32'(selerr3), 0);
    go(v(1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("sel3 start pc", 32'(pc3), 'h100);
    chk("sel3 start selerr", 32'(selerr3), 0);
    go(v(0, 0, 0, 0, 0, 3, 1, 0, 'h3AA, 0, 0, 0, 0, 0, 0));
    chk("sel3 bad write selerr", 32'(selerr3), 1);
    chk("sel4 write selerr", 32'(SelErr), 0);
    go(v(0, 0, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("sel4 branch pc", 32'(ProgCtr), 'h3AA);
    chk("sel3 bad branch pc", 32'(pc3), 'h102);
    go(v(0, 0, 0, 0, 0, 2, 1, 0, 'h0AB, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 3, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("sel3 good branch pc", 32'(pc3), 'h0AB);
    chk("sel3 selerr sticky", 32'(selerr3), 1);

`ifdef PC_CALL_STACK_EN
    do_reset();
    go(v(0, 0, 0, 0, 0, 0, 1, 0, 'h100, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 0, 0, 1, 1, 0, 'h200, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 0, 0, 2, 1, 0, 'h300, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 0, 0, 3, 1, 0, 'h080, 0, 0, 0, 0, 0, 0));
    chk("stk idle pc", 32'(ProgCtr), 0);
    go(v(1, 'h010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("call1 pc", 32'(ProgCtr), 'h100);
    go(v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("call2 pc", 32'(ProgCtr), 'h200);
    go(v(0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("call3 pc", 32'(ProgCtr), 'h300);
    go(v(0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("call4 pc", 32'(ProgCtr), 'h080);
    chk("call4 stkerr", 32'(StkErr), 0);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    chk("call5 overflow pc", 32'(ProgCtr), 'h081);
    chk("call5 stkerr", 32'(StkErr), 1);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("ret1 pc", 32'(ProgCtr), 'h301);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("ret2 pc", 32'(ProgCtr), 'h201);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("ret3 pc", 32'(ProgCtr), 'h101);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("ret4 pc", 32'(ProgCtr), 'h011);
    do_reset();
    chk("stk reset stkerr", 32'(StkErr), 0);
    go(v(1, 'h040, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("ret empty pc", 32'(ProgCtr), 'h041);
    chk("ret empty stkerr", 32'(StkErr), 1);
    // Call and Ret together: the Ret wins, so nothing is pushed.
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    chk("call+ret pc", 32'(ProgCtr), 'h042);
    go(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    chk("call+ret no push pc", 32'(ProgCtr), 'h043);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
